ifu_fetch_ctrl: RTL

Line-fetch sequencer for the front end: owns the fetch PC and issues one 512-bit (16-instruction) line request at a time to the memory arbiter. It paces requests against the instruction buffer's occupancy and tells the buffer each returned line's base PC and how many leading words to drop. On a redirect it flushes the buffer and discards any stale in-flight line. It sits between the branch/redirect logic, the memory arbiter and the instruction buffer.

---
 rtl/ifu_fetch_ctrl_if.sv | 26 ++
 rtl/ifu_fetch_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-side bus bundle: line request/response towards the memory arbiter
// and line delivery/flush towards the instruction buffer.
interface ifu_fetch_ctrl_if #(
  parameter int PC_W = 48
);
  logic            mem_req_valid;
  logic [PC_W-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic            line_valid;
  logic [PC_W-1:0] line_pc;
  logic [3:0]      line_skip;
  logic            ibuf_clear;
  logic [5:0]      ibuf_count;
  logic            ibuf_write_busy;

  modport master (
    output mem_req_valid, mem_req_addr, line_valid, line_pc, line_skip, ibuf_clear,
    input  mem_req_ready, mem_resp_valid, ibuf_count, ibuf_write_busy
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, line_valid, line_pc, line_skip, ibuf_clear,
    output mem_req_ready, mem_resp_valid, ibuf_count, ibuf_write_busy
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Line-fetch sequencer: one 64-byte line request outstanding at a time, paced by
// instruction-buffer occupancy. Optional perf counters behind IFU_PERF_CNT_EN.
//
// state | meaning
// IDLE  | first cycle after reset, request issued next cycle
// REQ   | mem_req_valid high, waiting for the arbiter to accept
// WAIT  | request accepted, waiting for the line response
// HOLD  | line delivered, waiting for buffer room before the next request
module ifu_fetch_ctrl #(
  parameter int              PC_W             = 48,
  parameter logic [PC_W-1:0] RESET_PC         = 48'h0000_8000_0000,
  parameter int              IBUF_DEPTH       = 24,
  parameter int              REFILL_THRESHOLD = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [PC_W-1:0]      redirect_pc,
  input  logic                 fetch_stall,
  ifu_fetch_ctrl_if.master     bus,
  output logic [31:0]          perf_lines,
  output logic [31:0]          perf_discards
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  // A full line must always fit, so the threshold is clamped to depth-16.
  localparam int         THR_MAX = IBUF_DEPTH - 16;
  localparam logic [5:0] THR     = 6'((REFILL_THRESHOLD > THR_MAX) ? THR_MAX : REFILL_THRESHOLD);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [3:0]      skip_q, skip_d;
  logic            discard_q, discard_d;
  logic            ibuf_clear_q, ibuf_clear_d;

  logic [PC_W-1:0] line_addr;
  logic            line_valid;
  logic            lines_inc;
  logic            discards_inc;
  logic            refill_ok;

  assign line_addr = {fetch_pc_q[PC_W-1:6], 6'b0};
  assign refill_ok = (bus.ibuf_count <= THR) && !bus.ibuf_write_busy && !fetch_stall;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    skip_d       = skip_q;
    discard_d    = discard_q;
    ibuf_clear_d = redirect_valid;
    line_valid   = 1'b0;
    lines_inc    = 1'b0;
    discards_inc = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (bus.mem_req_ready) state_d = WAIT;
      WAIT: begin
        if (bus.mem_resp_valid) begin
          if (!discard_q) begin
            line_valid = 1'b1;
            lines_inc  = 1'b1;
            fetch_pc_d = line_addr + PC_W'(64);
            skip_d     = 4'd0;
            state_d    = HOLD;
          end else begin
            discard_d    = 1'b0;
            discards_inc = 1'b1;
            state_d      = REQ;
          end
        end
      end
      HOLD: if (refill_ok) state_d = REQ;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
      skip_d     = redirect_pc[5:2];
      line_valid = 1'b0;
      lines_inc  = 1'b0;
      case (state_q)
        REQ: begin
          // The old address is already on the bus; if taken, its line is stale.
          if (bus.mem_req_ready) begin
            state_d   = WAIT;
            discard_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            discard_d    = 1'b0;
            discards_inc = 1'b1;
            state_d      = REQ;
          end else begin
            discard_d = 1'b1;
            state_d   = WAIT;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_pc_q   <= {RESET_PC[PC_W-1:2], 2'b00};
      skip_q       <= RESET_PC[5:2];
      discard_q    <= 1'b0;
      ibuf_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      skip_q       <= skip_d;
      discard_q    <= discard_d;
      ibuf_clear_q <= ibuf_clear_d;
    end
  end

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = line_addr;
  assign bus.line_valid    = line_valid;
  assign bus.line_pc       = line_addr;
  assign bus.line_skip     = skip_q;
  assign bus.ibuf_clear    = ibuf_clear_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_lines_q, perf_lines_d;
  logic [31:0] perf_discards_q, perf_discards_d;

  always_comb begin
    perf_lines_d    = perf_lines_q + {31'd0, lines_inc};
    perf_discards_d = perf_discards_q + {31'd0, discards_inc};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_lines_q    <= 32'd0;
      perf_discards_q <= 32'd0;
    end else begin
      perf_lines_q    <= perf_lines_d;
      perf_discards_q <= perf_discards_d;
    end
  end

  assign perf_lines    = perf_lines_q;
  assign perf_discards = perf_discards_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, redirect_pc[1:0], fetch_pc_q[5:0]};
`else
  assign perf_lines    = 32'd0;
  assign perf_discards = 32'd0;

  logic unused_bits;
  assign unused_bits = &{1'b0, redirect_pc[1:0], fetch_pc_q[5:0], lines_inc, discards_inc};
`endif

endmodule
